// File: rtl/initial_permutation_loader.sv
// Byte-serial DES input stage: assembles a 64-bit block MSB-first and presents
// IP(block) as L0/R0, with one extra block of buffering while the output is busy.
module initial_permutation_loader (
    input  logic        wClk,
    input  logic        wResetN,
    input  logic        wFlush,
    input  logic [7:0]  wByteIn,
    input  logic        wByteValid,
    output logic        rByteReady,
    output logic [31:0] rL0,
    output logic [31:0] rR0,
    output logic        rBlockValid,
    input  logic        wBlockReady,
    output logic        rDbgState
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Handshakes: a byte transfers on an edge where wByteValid & rByteReady;
    // a block transfers on an edge where rBlockValid & wBlockReady.

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [63:0] asm_q, asm_d;
    logic [31:0] l0_q, l0_d;
    logic [31:0] r0_q, r0_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        slot_free;
    logic [63:0] full_blk;
    logic [63:0] ip_full;
    logic [63:0] ip_held;

    // Output row r takes input bits base_r, base_r-8, ..., base_r-56 (DES numbering).
    function automatic logic [63:0] des_ip(input logic [63:0] blk);
        logic [63:0] o;
        int          base;
        o = '0;
        for (int r = 0; r < 8; r++) begin
            base = (r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4));
            for (int k = 0; k < 8; k++) begin
                o[63 - 8 * r - k] = blk[64 - base + 8 * k];
            end
        end
        return o;
    endfunction

    assign rByteReady  = (state_q == COLLECT);
    assign accept      = wByteValid & rByteReady;
    assign slot_free   = !valid_q | wBlockReady;
    assign full_blk    = {asm_q[55:0], wByteIn};
    assign ip_full     = des_ip(full_blk);
    assign ip_held     = des_ip(asm_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        asm_d   = asm_q;
        l0_d    = l0_q;
        r0_d    = r0_q;
        valid_d = valid_q;

        if (valid_q && wBlockReady) begin
            valid_d = 1'b0;
        end

        // Flush only touches the intake side; the output register keeps its block.
        if (wFlush) begin
            state_d = COLLECT;
            count_d = 3'd0;
            asm_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (count_q != 3'd7) begin
                            asm_d   = full_blk;
                            count_d = count_q + 3'd1;
                        end else begin
                            count_d = 3'd0;
                            if (slot_free) begin
                                l0_d    = ip_full[63:32];
                                r0_d    = ip_full[31:0];
                                valid_d = 1'b1;
                            end else begin
                                asm_d   = full_blk;
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        l0_d    = ip_held[63:32];
                        r0_d    = ip_held[31:0];
                        valid_d = 1'b1;
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge wClk) begin
        if (!wResetN) begin
            state_q <= COLLECT;
            count_q <= 3'd0;
            asm_q   <= '0;
            l0_q    <= '0;
            r0_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            asm_q   <= asm_d;
            l0_q    <= l0_d;
            r0_q    <= r0_d;
            valid_q <= valid_d;
        end
    end

    assign rL0         = l0_q;
    assign rR0         = r0_q;
    assign rBlockValid = valid_q;
    assign rDbgState   = state_q;

endmodule
